// File: rtl/wingen_pkg.sv
// Shared constants, FSM state type and inp byte-slice helper for window_gen_3x3.
package wingen_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_ROWS = 3;
  localparam int WIN_COLS = 3;
  localparam int WIN_TAPS = WIN_ROWS * WIN_COLS;

  typedef enum logic [1:0] {IDLE, RUN, BUBBLE, FLUSH} wingen_state_e;

  // LSB of the byte for window (row, col); row 0 / col 0 sits in the MSBs of inp.
  function automatic int win_lsb(input int row, input int col, input int dw);
    return (WIN_TAPS - 1 - (row * WIN_COLS + col)) * dw;
  endfunction

endpackage

// File: rtl/line_buffer_2row.sv
// Two stacked row buffers sharing one address: row1 takes the old row0 value
// while row0 takes din. Reads are combinational, so they see pre-write data.
module line_buffer_2row #(
  parameter int DEPTH = 640,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] row0,
  output logic [DW-1:0] row1
);

  logic [DW-1:0] lb0 [DEPTH];
  logic [DW-1:0] lb1 [DEPTH];

  assign row0 = lb0[addr];
  assign row1 = lb1[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= din;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 window generator with internal zero right column / bottom row.
// Optional frame_done pulse on the last window when WINGEN_FRAME_DONE_EN is defined.
module window_gen_3x3
  import wingen_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 640,
  parameter int DW    = PIX_W,
  parameter int CW    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [WIN_TAPS*DW-1:0] inp,
  output logic                 win_valid,
  output logic [CW-1:0]        counter_col,
  output logic [CW-1:0]        counter_row
`ifdef WINGEN_FRAME_DONE_EN
  ,
  output logic                 frame_done
`endif
);

  localparam int LB_AW = $clog2(IMG_W);
  localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] X_END  = CW'(IMG_W);
  localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] Y_END  = CW'(IMG_H);
  localparam logic [CW-1:0] TWO    = CW'(2);

  wingen_state_e state;
  logic [CW-1:0] x, y;
  logic [DW-1:0] win [WIN_ROWS][WIN_COLS];

  logic             transfer, shift_en, at_end, emit;
  logic [DW-1:0]    new_pix, lb_row0, lb_row1, col_top, col_mid;
  logic [LB_AW-1:0] lb_addr;

  // Handshake: a pixel moves when pix_valid && pix_ready at a rising edge;
  // pix_ready is registered and never depends on pix_valid.
  assign transfer = pix_valid & pix_ready;
  // x == IMG_W marks the zero-column cycle (row bubble or end of flush row).
  assign at_end   = (x == X_END);
  assign shift_en = transfer | (state == BUBBLE) | (state == FLUSH);
  assign new_pix  = transfer ? pix_in : '0;
  assign lb_addr  = at_end ? '0 : x[LB_AW-1:0];
  assign col_top  = at_end ? '0 : lb_row1;
  assign col_mid  = at_end ? '0 : lb_row0;
  assign emit     = shift_en & (y >= TWO) & (x >= TWO);

  line_buffer_2row #(
    .DEPTH(IMG_W),
    .DW   (DW),
    .AW   (LB_AW)
  ) u_lb (
    .clk (clk),
    .we  (shift_en & ~at_end),
    .addr(lb_addr),
    .din (new_pix),
    .row0(lb_row0),
    .row1(lb_row1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      pix_ready   <= 1'b0;
      win_valid   <= 1'b0;
      counter_col <= '0;
      counter_row <= '0;
      for (int r = 0; r < WIN_ROWS; r++)
        for (int c = 0; c < WIN_COLS; c++)
          win[r][c] <= '0;
    end else begin
      if (shift_en) begin
        for (int r = 0; r < WIN_ROWS; r++)
          for (int c = 0; c < WIN_COLS - 1; c++)
            win[r][c] <= win[r][c+1];
        win[0][WIN_COLS-1] <= col_top;
        win[1][WIN_COLS-1] <= col_mid;
        win[2][WIN_COLS-1] <= new_pix;
      end

      win_valid <= emit;
      if (emit) begin
        counter_col <= x - TWO;
        counter_row <= y - TWO;
      end

      case (state)
        IDLE, RUN: begin
          pix_ready <= 1'b1;
          if (transfer) begin
            state <= RUN;
            if (x == X_LAST) begin
              x         <= X_END;
              state     <= BUBBLE;
              pix_ready <= 1'b0;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        BUBBLE: begin
          x <= '0;
          if (y == Y_LAST) begin
            y     <= Y_END;
            state <= FLUSH;
          end else begin
            y         <= y + 1'b1;
            state     <= RUN;
            pix_ready <= 1'b1;
          end
        end
        FLUSH: begin
          if (at_end) begin
            x         <= '0;
            y         <= '0;
            state     <= IDLE;
            pix_ready <= 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    inp = '0;
    for (int r = 0; r < WIN_ROWS; r++)
      for (int c = 0; c < WIN_COLS; c++)
        inp[win_lsb(r, c, DW) +: DW] = win[r][c];
  end

`ifdef WINGEN_FRAME_DONE_EN
  // Last window is the one produced by the zero-column cycle of the flush row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= emit & at_end & (y == Y_END);
  end
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomised-stall bench for window_gen_3x3 with a frame-level window model.
module tb_window_gen_3x3;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int DW = 8;
  localparam int CW = 10;
  localparam int EW = 2 * CW + 9 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [9*DW-1:0] inp;
  logic          win_valid;
  logic [CW-1:0] counter_col, counter_row;
`ifdef WINGEN_FRAME_DONE_EN
  logic          frame_done;
`endif

  int checks = 0, errors = 0, cyc = 0, low_cnt = 0, win_cnt = 0;
  int img [H][W];
  int xfer_edge [H][W];
  logic [EW-1:0] exp_q[$];

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .inp        (inp),
    .win_valid  (win_valid),
    .counter_col(counter_col),
    .counter_row(counter_row)
`ifdef WINGEN_FRAME_DONE_EN
    ,
    .frame_done (frame_done)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] px(input int r, input int c);
    if (r >= H || c >= W) return '0;
    return DW'(img[r][c]);
  endfunction

  // Reference model: every window of the frame, padded with zeros past the edges.
  task automatic build_frame(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c] = (mode == 0) ? (r * W + c) : int'($urandom_range(0, 255));
        xfer_edge[r][c] = -1;
      end
    for (int r = 0; r < H - 1; r++)
      for (int c = 0; c < W - 1; c++) begin
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[(8 - (i * 3 + j)) * DW +: DW] = px(r + i, c + j);
        exp_q.push_back({CW'(c), CW'(r), w});
      end
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (pix_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check(tag, EW'(pix_ready), EW'(1));
  endtask

  // driver
  task automatic drive(input int pct, input int npix);
    int idx = 0;
    int g = 0;
    while (idx < npix && g < 1000) begin
      @(negedge clk);
      g++;
      pix_in    = DW'(img[idx / W][idx % W]);
      pix_valid = ($urandom_range(1, 100) <= pct);
      if (pix_valid && pix_ready) begin
        xfer_edge[idx / W][idx % W] = cyc + 1;
        idx++;
      end
    end
    check("drive_budget", EW'(idx), EW'(npix));
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input int mode, input int pct, input string tag);
    build_frame(mode);
    wait_ready({tag, "_start_ready"});
    low_cnt = 0;
    win_cnt = 0;
    drive(pct, W * H);
    wait_ready({tag, "_end_ready"});
    @(negedge clk);
    check({tag, "_ready_low_cycles"}, EW'(low_cnt), EW'(H + W + 1));
    check({tag, "_window_count"}, EW'(win_cnt), EW'((W - 1) * (H - 1)));
    check({tag, "_queue_empty"}, EW'(exp_q.size()), EW'(0));
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int ec, er;
    if (!rst) begin
      if (pix_ready !== 1'b1) low_cnt++;
      if (win_valid === 1'b1) begin
        win_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_window", EW'(exp_q.size()), EW'(1));
        end else begin
          e  = exp_q.pop_front();
          ec = int'(e[EW-1 -: CW]);
          er = int'(e[EW-1-CW -: CW]);
          check("counter_col", EW'(counter_col), EW'(e[EW-1 -: CW]));
          check("counter_row", EW'(counter_row), EW'(e[EW-1-CW -: CW]));
          check("inp", EW'(inp), EW'(e[9*DW-1:0]));
          if (ec + 2 < W && er + 2 < H)
            check("latency", EW'(cyc), EW'(xfer_edge[er+2][ec+2]));
`ifdef WINGEN_FRAME_DONE_EN
          check("frame_done", EW'(frame_done), EW'(ec == W - 2 && er == H - 2));
`endif
        end
      end else begin
`ifdef WINGEN_FRAME_DONE_EN
        check("frame_done_idle", EW'(frame_done), EW'(0));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_inp", EW'(inp), EW'(0));
    check("rst_win_valid", EW'(win_valid), EW'(0));
    check("rst_counter_col", EW'(counter_col), EW'(0));
    check("rst_counter_row", EW'(counter_row), EW'(0));
    check("rst_pix_ready", EW'(pix_ready), EW'(0));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", EW'(pix_ready), EW'(1));

    run_frame(0, 100, "ramp");
    run_frame(0, 50, "ramp_stall");

    // Abort a random frame in row 3 with an asynchronous reset between edges.
    build_frame(1);
    wait_ready("partial_start_ready");
    drive(100, 3 * W + 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_inp", EW'(inp), EW'(0));
    check("midrst_win_valid", EW'(win_valid), EW'(0));
    check("midrst_counter_col", EW'(counter_col), EW'(0));
    check("midrst_counter_row", EW'(counter_row), EW'(0));
    check("midrst_pix_ready", EW'(pix_ready), EW'(0));
`ifdef WINGEN_FRAME_DONE_EN
    check("midrst_frame_done", EW'(frame_done), EW'(0));
`endif
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_frame(1, 70, "rand_after_rst");
    run_frame(1, 100, "rand_b2b");
    run_frame(1, 40, "rand_stall");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
